lector_destinos: RTL and testbench

- Drain stage directly downstream of the D0/D1 destination FIFOs of the QoS path.
- Pops each destination FIFO whenever it holds data, the FIFO reports no error and the sink is ready.
- Presents each popped word on a registered per-destination output with a one-cycle valid strobe.
- Keeps per-destination packet counters; software reads them through a req/idx handshake while the flow FSM is idle.

---
 rtl/lector_destinos_pkg.sv | 17 +
 rtl/canal_lector.sv | 62 ++++++
 rtl/lector_destinos.sv | 80 ++++++++
 tb/tb_lector_destinos.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/lector_destinos_pkg.sv
// Shared defaults and encodings for the destination drain stage.
package lector_destinos_pkg;
  localparam int BW_DEF = 6;
  localparam int CW_DEF = 5;

  typedef enum logic [1:0] {
    IDX_D0  = 2'd0,
    IDX_D1  = 2'd1,
    IDX_SUM = 2'd2,
    IDX_RSV = 2'd3
  } idx_e;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } ch_state_e;
endpackage

// File: rtl/canal_lector.sv
// One destination channel: pop strobe, 2-stage read pipe, RUN/HALT FSM, packet counter.
// LECTOR_SAT_EN: counter saturates at all-ones instead of wrapping.
module canal_lector
  import lector_destinos_pkg::*;
#(
  parameter int BW = BW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          init,
  input  logic          empty,
  input  logic          error_output,
  input  logic [BW-1:0] data_out,
  input  logic          ready,
  output logic          rd,
  output logic [BW-1:0] pkt,
  output logic          valid,
  output logic          err,
  output logic [CW-1:0] cnt
);
  localparam int STAGES = 2;

  ch_state_e         state, state_nxt;
  logic [STAGES:1]   vld_pipe;
  logic [CW-1:0]     cnt_inc;

  assign err   = (state == HALT);
  assign rd    = reset_L & ~empty & ~error_output & ready & ~err;
  assign valid = vld_pipe[STAGES];

  // init releases HALT even if an error is reported in the same cycle
  always_comb begin
    state_nxt = state;
    if (init)              state_nxt = RUN;
    else if (error_output) state_nxt = HALT;
  end

  always_comb begin
`ifdef LECTOR_SAT_EN
    cnt_inc = (&cnt) ? cnt : cnt + CW'(1);
`else
    cnt_inc = cnt + CW'(1);
`endif
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state    <= RUN;
      vld_pipe <= '0;
      pkt      <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      vld_pipe <= {vld_pipe[STAGES-1:1], rd};
      // FIFO data is valid the cycle after the pop, i.e. alongside stage 1
      if (vld_pipe[1]) pkt <= data_out;
      if (init)          cnt <= '0;
      else if (valid)    cnt <= cnt_inc;
    end
  end
endmodule

// File: rtl/lector_destinos.sv
// D0/D1 destination FIFO drain with per-channel counters and an idle-gated counter read port.
// LECTOR_SAT_EN (in canal_lector) selects saturating counters.
module lector_destinos
  import lector_destinos_pkg::*;
#(
  parameter int BW = BW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          init,
  input  logic          idle_in,
  input  logic          D0_empty,
  input  logic          D1_empty,
  input  logic          D0_error_output,
  input  logic          D1_error_output,
  input  logic [BW-1:0] D0_data_out,
  input  logic [BW-1:0] D1_data_out,
  input  logic          D0_ready,
  input  logic          D1_ready,
  output logic          D0_rd,
  output logic          D1_rd,
  output logic [BW-1:0] D0_pkt,
  output logic [BW-1:0] D1_pkt,
  output logic          D0_valid,
  output logic          D1_valid,
  output logic [1:0]    err_sticky,
  input  logic          req,
  input  logic [1:0]    idx,
  output logic [CW:0]   cnt_data,
  output logic          cnt_valid
);
  logic [1:0]          empty, error_output, ready, rd, valid;
  logic [1:0][BW-1:0]  data_out, pkt;
  logic [1:0][CW-1:0]  cnt;
  logic [CW:0]         cnt_sel;
  logic                rd_ok;

  assign empty        = {D1_empty, D0_empty};
  assign error_output = {D1_error_output, D0_error_output};
  assign ready        = {D1_ready, D0_ready};
  assign data_out     = {D1_data_out, D0_data_out};
  assign {D1_rd, D0_rd}       = rd;
  assign {D1_valid, D0_valid} = valid;
  assign D0_pkt = pkt[0];
  assign D1_pkt = pkt[1];

  for (genvar n = 0; n < 2; n++) begin : g_canal
    canal_lector #(.BW(BW), .CW(CW)) u_canal (
      .clk(clk), .reset_L(reset_L), .init(init),
      .empty(empty[n]), .error_output(error_output[n]),
      .data_out(data_out[n]), .ready(ready[n]),
      .rd(rd[n]), .pkt(pkt[n]), .valid(valid[n]),
      .err(err_sticky[n]), .cnt(cnt[n])
    );
  end

  assign rd_ok = req & idle_in;

  always_comb begin
    cnt_sel = '0;
    case (idx_e'(idx))
      IDX_D0:  cnt_sel = {1'b0, cnt[0]};
      IDX_D1:  cnt_sel = {1'b0, cnt[1]};
      IDX_SUM: cnt_sel = {1'b0, cnt[0]} + {1'b0, cnt[1]};
      default: cnt_sel = '0;
    endcase
  end

  // registered response samples counters before this edge's increment
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cnt_valid <= 1'b0;
      cnt_data  <= '0;
    end else begin
      cnt_valid <= rd_ok;
      cnt_data  <= rd_ok ? cnt_sel : '0;
    end
  end
endmodule

// File: tb/tb_lector_destinos.sv
// Randomized self-checking bench for lector_destinos against a queue-based FIFO/sink model.
module tb_lector_destinos;
  localparam int BW = 6;
  localparam int CW = 5;

  logic          clk = 1'b0, reset_L = 1'b0, init = 1'b0, idle_in = 1'b0, req = 1'b0;
  logic [1:0]    idx = 2'd0;
  logic [1:0]    empty = 2'b11, err_in = 2'b00, ready = 2'b00;
  logic [1:0]    rd, valid, err_sticky;
  logic [BW-1:0] dout [2];
  logic [BW-1:0] pkt  [2];
  logic [CW:0]   cnt_data;
  logic          cnt_valid;

  always #5 clk = ~clk;

  lector_destinos #(.BW(BW), .CW(CW)) dut (
    .clk(clk), .reset_L(reset_L), .init(init), .idle_in(idle_in),
    .D0_empty(empty[0]), .D1_empty(empty[1]),
    .D0_error_output(err_in[0]), .D1_error_output(err_in[1]),
    .D0_data_out(dout[0]), .D1_data_out(dout[1]),
    .D0_ready(ready[0]), .D1_ready(ready[1]),
    .D0_rd(rd[0]), .D1_rd(rd[1]),
    .D0_pkt(pkt[0]), .D1_pkt(pkt[1]),
    .D0_valid(valid[0]), .D1_valid(valid[1]),
    .err_sticky(err_sticky), .req(req), .idx(idx),
    .cnt_data(cnt_data), .cnt_valid(cnt_valid)
  );

  // model: FIFO contents, words in flight, delivered stream, packet counts
  logic [BW-1:0] q [2][$];
  logic [BW-1:0] m_w1 [2], m_pkt [2];
  bit            m_halt [2], m_rd1 [2], m_valid [2], exp_rd [2];
  int            m_cnt [2];
  bit            m_cv;
  int            m_cd;
  int            v_seen [2];
  int            n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int inc(input int c);
`ifdef LECTOR_SAT_EN
    return (c == (1 << CW) - 1) ? c : c + 1;
`else
    return (c + 1) % (1 << CW);
`endif
  endfunction

  function automatic int sel_cnt(input logic [1:0] i);
    case (i)
      2'd0:    return m_cnt[0];
      2'd1:    return m_cnt[1];
      2'd2:    return m_cnt[0] + m_cnt[1];
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_halt[n] = 0; m_rd1[n] = 0; m_valid[n] = 0; m_pkt[n] = '0; m_cnt[n] = 0;
    end
    m_cv = 0; m_cd = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd"}, rd, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_pkt0"}, pkt[0], 0);
    chk({tag, "_pkt1"}, pkt[1], 0);
    chk({tag, "_err"}, err_sticky, 0);
    chk({tag, "_cv"}, cnt_valid, 0);
    chk({tag, "_cd"}, cnt_data, 0);
  endtask

  // one clock: starts and ends at negedge, inputs already applied
  task automatic cycle();
    for (int n = 0; n < 2; n++) empty[n] = (q[n].size() == 0);
    #1;
    for (int n = 0; n < 2; n++)
      exp_rd[n] = reset_L && q[n].size() != 0 && !err_in[n] && ready[n] && !m_halt[n];
    chk("rd0", rd[0], exp_rd[0]);
    chk("rd1", rd[1], exp_rd[1]);
    @(posedge clk);
    if (reset_L) begin
      m_cv = req && idle_in;
      m_cd = m_cv ? sel_cnt(idx) : 0;
      for (int n = 0; n < 2; n++) begin
        if (init) m_cnt[n] = 0;
        else if (m_valid[n]) m_cnt[n] = inc(m_cnt[n]);
        m_valid[n] = m_rd1[n];
        if (m_rd1[n]) m_pkt[n] = m_w1[n];
        m_rd1[n] = exp_rd[n];
        if (exp_rd[n]) m_w1[n] = q[n].pop_front();
        if (init) m_halt[n] = 0;
        else if (err_in[n]) m_halt[n] = 1;
      end
    end
    #1;
    for (int n = 0; n < 2; n++) dout[n] = m_w1[n];
    chk("valid0", valid[0], m_valid[0]);
    chk("valid1", valid[1], m_valid[1]);
    chk("pkt0", pkt[0], m_pkt[0]);
    chk("pkt1", pkt[1], m_pkt[1]);
    chk("err_sticky", err_sticky, {m_halt[1], m_halt[0]});
    chk("cnt_valid", cnt_valid, m_cv);
    chk("cnt_data", cnt_data, m_cd);
    for (int n = 0; n < 2; n++) v_seen[n] += valid[n];
    @(negedge clk);
  endtask

  task automatic read_cnt(input logic [1:0] i, input logic idl);
    req = 1; idx = i; idle_in = idl;
    cycle();
    req = 0; idle_in = 1;
  endtask

  task automatic pulse_init();
    init = 1; cycle(); init = 0;
  endtask

  initial begin
    model_reset();
    for (int n = 0; n < 2; n++) begin m_w1[n] = '0; dout[n] = '0; v_seen[n] = 0; end
    repeat (2) @(negedge clk);
    #1 chk_zero("reset");
    @(negedge clk);
    reset_L = 1;

    // basic drain
    q[0].push_back(6'b10_0001); q[0].push_back(6'b10_1100); q[0].push_back(6'b10_0001);
    ready = 2'b11; idle_in = 1;
    repeat (6) cycle();
    read_cnt(2'd0, 1);
    chk("drain_cnt", cnt_data, 3);
    chk("drain_cv", cnt_valid, 1);

    // back-pressure after two pops
    for (int k = 0; k < 4; k++) q[0].push_back(BW'(k + 5));
    v_seen[0] = 0;
    cycle(); cycle();
    ready[0] = 0;
    repeat (4) cycle();
    chk("bp_valids", v_seen[0], 2);
    ready[0] = 1;
    repeat (5) cycle();
    chk("bp_drained", v_seen[0], 4);

    // error halt on D1, then init
    for (int k = 0; k < 3; k++) q[1].push_back(BW'(k + 40));
    err_in[1] = 1; cycle(); err_in[1] = 0;
    repeat (3) cycle();
    chk("halt_err", err_sticky, 2'b10);
    chk("halt_rd1", rd[1], 0);
    v_seen[1] = 0;
    pulse_init();
    repeat (5) cycle();
    chk("resume_err", err_sticky, 0);
    chk("resume_valids", v_seen[1], 3);

    // counter sum and idle gating
    pulse_init();
    for (int k = 0; k < 15; k++) q[0].push_back(BW'($urandom));
    for (int k = 0; k < 14; k++) q[1].push_back(BW'($urandom));
    repeat (20) cycle();
    read_cnt(2'd2, 1);
    chk("sum", cnt_data, 29);
    read_cnt(2'd2, 0);
    chk("gate_cv", cnt_valid, 0);
    read_cnt(2'd3, 1);
    chk("rsv_cv", cnt_valid, 1);

    // wrap / saturate
    pulse_init();
    for (int k = 0; k < 33; k++) q[0].push_back(BW'($urandom));
    repeat (38) cycle();
    read_cnt(2'd0, 1);
`ifdef LECTOR_SAT_EN
    chk("wrap_sat", cnt_data, 31);
`else
    chk("wrap_sat", cnt_data, 1);
`endif

    // reset mid-stream while D0_rd is high
    for (int k = 0; k < 4; k++) q[0].push_back(BW'(k + 20));
    cycle();
    empty[0] = (q[0].size() == 0);
    #2;
    chk("mid_rd_pre", rd[0], 1);
    reset_L = 0;
    #1 chk_zero("mid_reset");
    model_reset();
    @(posedge clk); @(negedge clk);
    reset_L = 1;
    ready = 2'b00;
    repeat (3) cycle();
    ready = 2'b11;
    repeat (6) cycle();

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(2) == 0) begin
        int ch;
        ch = $urandom_range(1);
        if (q[ch].size() < 8) q[ch].push_back(BW'($urandom));
      end
      ready   = {($urandom_range(3) != 0), ($urandom_range(3) != 0)};
      err_in  = {($urandom_range(59) == 0), ($urandom_range(59) == 0)};
      init    = ($urandom_range(24) == 0);
      req     = $urandom_range(1);
      idx     = 2'($urandom_range(3));
      idle_in = ($urandom_range(4) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
